// File: rtl/riscv_multi.sv
// riscv_multi: multicycle RV32I-subset core on a single unified memory bus with a MemReady handshake.
// Optional feature: define RV_SHIFT_EN to decode sll/srl/sra/slli/srli/srai; otherwise those encodings halt.
module riscv_multi #(
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000,
  parameter int unsigned DATA_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] Adr,
  output logic [31:0] WriteData,
  output logic        MemWrite,
  output logic        MemRead,
  input  logic [31:0] ReadData,
  input  logic        MemReady,
  output logic        Halted
);

  generate
    if (DATA_W != 32) begin : g_bad_width
      $error("riscv_multi: DATA_W must be 32");
    end
  endgenerate

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JAL, LUI, HALT
  } state_t;

  state_t             state;
  state_t             dec_next;
  logic [31:0]        pc;
  logic [31:0]        old_pc;
  logic [31:0]        instr;
  logic [DATA_W-1:0]  alu_out;
  logic [DATA_W-1:0]  mdr;
  logic [DATA_W-1:0]  rf [32];

  logic [6:0]         opcode;
  logic [4:0]         rd;
  logic [4:0]         rs1;
  logic [4:0]         rs2;
  logic [2:0]         funct3;
  logic [31:0]        imm_i;
  logic [31:0]        imm_s;
  logic [31:0]        imm_b;
  logic [31:0]        imm_j;
  logic [31:0]        imm_u;
  logic [DATA_W-1:0]  rs1_val;
  logic [DATA_W-1:0]  rs2_val;
  logic [DATA_W-1:0]  alu_b;
  logic [DATA_W-1:0]  alu_res;
  logic               is_sub;
  logic [31:0]        br_target;
  logic               br_taken;

  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  assign imm_u  = {instr[31:12], 12'b0};

  assign rs1_val   = (rs1 == 5'd0) ? '0 : rf[rs1];
  assign rs2_val   = (rs2 == 5'd0) ? '0 : rf[rs2];
  assign br_target = old_pc + imm_b;
  assign br_taken  = (funct3 == 3'b000) ? (rs1_val == rs2_val) : (rs1_val != rs2_val);

  function automatic logic alu_f3_ok(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b010, 3'b100, 3'b110, 3'b111: alu_f3_ok = 1'b1;
`ifdef RV_SHIFT_EN
      3'b001, 3'b101:                         alu_f3_ok = 1'b1;
`endif
      default:                                alu_f3_ok = 1'b0;
    endcase
  endfunction

  always_comb begin
    dec_next = HALT;
    case (opcode)
      OP_LOAD, OP_STORE: if (funct3 == 3'b010) dec_next = MEMADR;
      OP_R:              if (alu_f3_ok(funct3)) dec_next = EXECR;
      OP_I:              if (alu_f3_ok(funct3)) dec_next = EXECI;
      OP_BR:             if (funct3 == 3'b000 || funct3 == 3'b001) dec_next = BRANCH;
      OP_JAL:            dec_next = JAL;
      OP_LUI:            dec_next = LUI;
      default:           dec_next = HALT;
    endcase
  end

  // instr[30] selects sub only for R-type; in I-type it is an immediate bit
  assign alu_b  = (state == EXECR) ? rs2_val : imm_i;
  assign is_sub = (state == EXECR) && instr[30];

  always_comb begin
    alu_res = '0;
    case (funct3)
      3'b000:  alu_res = is_sub ? rs1_val - alu_b : rs1_val + alu_b;
      3'b010:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(rs1_val) < $signed(alu_b))};
      3'b100:  alu_res = rs1_val ^ alu_b;
      3'b110:  alu_res = rs1_val | alu_b;
      3'b111:  alu_res = rs1_val & alu_b;
`ifdef RV_SHIFT_EN
      3'b001:  alu_res = rs1_val << alu_b[4:0];
      3'b101:  alu_res = instr[30] ? DATA_W'($signed(rs1_val) >>> alu_b[4:0])
                                   : rs1_val >> alu_b[4:0];
`endif
      default: alu_res = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= FETCH;
      pc        <= RESET_ADDR;
      old_pc    <= RESET_ADDR;
      instr     <= '0;
      alu_out   <= '0;
      mdr       <= '0;
      Adr       <= RESET_ADDR;
      WriteData <= '0;
      MemRead   <= 1'b1;
      MemWrite  <= 1'b0;
      Halted    <= 1'b0;
    end else begin
      case (state)
        FETCH: if (MemReady) begin
          instr   <= ReadData;
          old_pc  <= pc;
          pc      <= pc + 32'd4;
          MemRead <= 1'b0;
          state   <= DECODE;
        end
        DECODE: begin
          state <= dec_next;
          if (dec_next == HALT) Halted <= 1'b1;
        end
        MEMADR: begin
          if (opcode == OP_STORE) begin
            Adr       <= rs1_val + imm_s;
            WriteData <= rs2_val;
            MemWrite  <= 1'b1;
            state     <= MEMWRITE;
          end else begin
            Adr     <= rs1_val + imm_i;
            MemRead <= 1'b1;
            state   <= MEMREAD;
          end
        end
        MEMREAD: if (MemReady) begin
          mdr     <= ReadData;
          MemRead <= 1'b0;
          state   <= MEMWB;
        end
        MEMWRITE: if (MemReady) begin
          MemWrite <= 1'b0;
          MemRead  <= 1'b1;
          Adr      <= pc;
          state    <= FETCH;
        end
        EXECR, EXECI: begin
          alu_out <= alu_res;
          state   <= ALUWB;
        end
        JAL: begin
          alu_out <= old_pc + 32'd4;
          pc      <= old_pc + imm_j;
          state   <= ALUWB;
        end
        LUI: begin
          alu_out <= imm_u;
          state   <= ALUWB;
        end
        MEMWB, ALUWB: begin
          Adr     <= pc;
          MemRead <= 1'b1;
          state   <= FETCH;
        end
        // Adr is loaded with the resolved target so the next fetch needs no extra cycle
        BRANCH: begin
          if (br_taken) begin
            pc  <= br_target;
            Adr <= br_target;
          end else begin
            Adr <= pc;
          end
          MemRead <= 1'b1;
          state   <= FETCH;
        end
        HALT: Halted <= 1'b1;
        default: begin
          Halted <= 1'b1;
          state  <= HALT;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rd != 5'd0) begin
      if (state == MEMWB)      rf[rd] <= mdr;
      else if (state == ALUWB) rf[rd] <= alu_out;
    end
  end

endmodule

// File: tb/tb_riscv_multi.sv
// tb_riscv_multi: random RV32I-subset programs run against an instruction-level reference model;
// a memory responder with random wait states checks every bus transaction against a scoreboard queue.
`timescale 1ns/1ps
module tb_riscv_multi;

  localparam logic [31:0] RST_PC = 32'h100;
`ifdef RV_SHIFT_EN
  localparam bit SHIFT_EN = 1'b1;
`else
  localparam bit SHIFT_EN = 1'b0;
`endif

  localparam int O_ADD = 0,  O_SUB = 1,  O_AND = 2,  O_OR = 3,  O_XOR = 4,  O_SLT = 5;
  localparam int O_ADDI = 6, O_ANDI = 7, O_ORI = 8,  O_XORI = 9, O_SLTI = 10;
  localparam int O_SLL = 11, O_SRL = 12, O_SRA = 13, O_SLLI = 14, O_SRLI = 15, O_SRAI = 16;
  localparam int O_LW = 17,  O_SW = 18,  O_BEQ = 19, O_BNE = 20, O_JAL = 21, O_LUI = 22, O_ILL = 23;

  typedef struct { int op; int rd; int rs1; int rs2; int imm; } op_t;
  typedef struct { int kind; logic [31:0] addr; logic [31:0] data; int lat; } txn_t; // kind 0 fetch,1 load,2 store

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] Adr, WriteData, ReadData;
  logic        MemWrite, MemRead, MemReady, Halted;

  op_t         prog[$];
  txn_t        exp_q[$];
  logic [31:0] mem [0:1023];
  int          tests = 0;
  int          fails = 0;

  riscv_multi #(.RESET_ADDR(RST_PC), .DATA_W(32)) dut (
    .clk(clk), .reset(reset), .Adr(Adr), .WriteData(WriteData), .MemWrite(MemWrite),
    .MemRead(MemRead), .ReadData(ReadData), .MemReady(MemReady), .Halted(Halted)
  );

  always #5 clk = ~clk;

  function automatic op_t mk(int op, int rd, int rs1, int rs2, int imm);
    op_t o;
    o.op = op; o.rd = rd; o.rs1 = rs1; o.rs2 = rs2; o.imm = imm;
    return o;
  endfunction

  function automatic bit is_shift(int op);
    return op >= O_SLL && op <= O_SRAI;
  endfunction

  function automatic logic [31:0] enc(op_t o);
    logic [31:0] im;
    logic [4:0]  rd, r1, r2;
    im = 32'(o.imm); rd = 5'(o.rd); r1 = 5'(o.rs1); r2 = 5'(o.rs2);
    case (o.op)
      O_ADD:  return {7'h00, r2, r1, 3'b000, rd, 7'b0110011};
      O_SUB:  return {7'h20, r2, r1, 3'b000, rd, 7'b0110011};
      O_SLL:  return {7'h00, r2, r1, 3'b001, rd, 7'b0110011};
      O_SLT:  return {7'h00, r2, r1, 3'b010, rd, 7'b0110011};
      O_XOR:  return {7'h00, r2, r1, 3'b100, rd, 7'b0110011};
      O_SRL:  return {7'h00, r2, r1, 3'b101, rd, 7'b0110011};
      O_SRA:  return {7'h20, r2, r1, 3'b101, rd, 7'b0110011};
      O_OR:   return {7'h00, r2, r1, 3'b110, rd, 7'b0110011};
      O_AND:  return {7'h00, r2, r1, 3'b111, rd, 7'b0110011};
      O_ADDI: return {im[11:0], r1, 3'b000, rd, 7'b0010011};
      O_SLTI: return {im[11:0], r1, 3'b010, rd, 7'b0010011};
      O_XORI: return {im[11:0], r1, 3'b100, rd, 7'b0010011};
      O_ORI:  return {im[11:0], r1, 3'b110, rd, 7'b0010011};
      O_ANDI: return {im[11:0], r1, 3'b111, rd, 7'b0010011};
      O_SLLI: return {7'h00, im[4:0], r1, 3'b001, rd, 7'b0010011};
      O_SRLI: return {7'h00, im[4:0], r1, 3'b101, rd, 7'b0010011};
      O_SRAI: return {7'h20, im[4:0], r1, 3'b101, rd, 7'b0010011};
      O_LW:   return {im[11:0], r1, 3'b010, rd, 7'b0000011};
      O_SW:   return {im[11:5], r2, r1, 3'b010, im[4:0], 7'b0100011};
      O_BEQ:  return {im[12], im[10:5], r2, r1, 3'b000, im[4:1], im[11], 7'b1100011};
      O_BNE:  return {im[12], im[10:5], r2, r1, 3'b001, im[4:1], im[11], 7'b1100011};
      O_JAL:  return {im[20], im[10:1], im[11], im[19:12], rd, 7'b1101111};
      O_LUI:  return {im[19:0], rd, 7'b0110111};
      default: return 32'h0000_007F;
    endcase
  endfunction

  function automatic int latency(int op);
    if (op == O_LW) return 5;
    if (op == O_BEQ || op == O_BNE) return 3;
    return 4;
  endfunction

  function automatic op_t rand_alu();
    op_t o;
    int  k;
    k = int'($urandom_range(0, SHIFT_EN ? 16 : 10));
    o.op  = k;
    o.rd  = int'($urandom_range(0, 10));
    o.rs1 = int'($urandom_range(0, 10));
    o.rs2 = int'($urandom_range(0, 10));
    o.imm = is_shift(k) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4095)) - 2048;
    return o;
  endfunction

  // Instruction-level model: walks the abstract program and lists the bus traffic it must produce.
  task automatic run_model();
    logic [31:0] x [32];
    logic [31:0] m [0:1023];
    logic [31:0] pc, npc, a, b, r, ea, im;
    txn_t        t;
    op_t         o;
    bit          wr;
    int          idx;
    m = mem;
    for (int i = 0; i < 32; i++) x[i] = '0;
    pc = RST_PC;
    for (int step = 0; step < 4000; step++) begin
      idx = int'((pc - RST_PC) >> 2);
      if (idx < 0 || idx >= prog.size()) break;
      o = prog[idx];
      t.kind = 0; t.addr = pc; t.data = '0; t.lat = latency(o.op);
      exp_q.push_back(t);
      if (o.op == O_ILL || (is_shift(o.op) && !SHIFT_EN)) break;
      a = x[o.rs1]; b = x[o.rs2]; im = 32'(o.imm); npc = pc + 4; wr = 1'b1; r = '0;
      case (o.op)
        O_ADD:  r = a + b;
        O_SUB:  r = a - b;
        O_AND:  r = a & b;
        O_OR:   r = a | b;
        O_XOR:  r = a ^ b;
        O_SLT:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        O_ADDI: r = a + im;
        O_ANDI: r = a & im;
        O_ORI:  r = a | im;
        O_XORI: r = a ^ im;
        O_SLTI: r = ($signed(a) < $signed(im)) ? 32'd1 : 32'd0;
        O_SLL:  r = a << b[4:0];
        O_SRL:  r = a >> b[4:0];
        O_SRA:  r = 32'($signed(a) >>> b[4:0]);
        O_SLLI: r = a << o.imm;
        O_SRLI: r = a >> o.imm;
        O_SRAI: r = 32'($signed(a) >>> o.imm);
        O_LW: begin
          ea = a + im; r = m[ea[11:2]];
          t.kind = 1; t.addr = ea; t.data = r; t.lat = 0; exp_q.push_back(t);
        end
        O_SW: begin
          ea = a + im; m[ea[11:2]] = b; wr = 1'b0;
          t.kind = 2; t.addr = ea; t.data = b; t.lat = 0; exp_q.push_back(t);
        end
        O_BEQ: begin wr = 1'b0; if (a == b) npc = pc + im; end
        O_BNE: begin wr = 1'b0; if (a != b) npc = pc + im; end
        O_JAL: begin r = pc + 4; npc = pc + im; end
        O_LUI: r = im << 12;
        default: wr = 1'b0;
      endcase
      if (wr && o.rd != 0) x[o.rd] = r;
      pc = npc;
    end
  endtask

  task automatic build_program();
    int k;
    prog.push_back(mk(O_ADDI, 1, 0, 0, 5));
    prog.push_back(mk(O_ADDI, 2, 0, 0, -3));
    prog.push_back(mk(O_ADD,  3, 1, 2, 0));
    prog.push_back(mk(O_SW,   0, 0, 3, 'h6C));
    prog.push_back(mk(O_LUI,  5, 0, 0, 'hABCDE));
    prog.push_back(mk(O_ADDI, 5, 5, 0, 'h7D5));
    prog.push_back(mk(O_SW,   0, 0, 5, 'h70));
    prog.push_back(mk(O_LW,   6, 0, 0, 'h40));
    prog.push_back(mk(O_SW,   0, 0, 6, 'h74));
    prog.push_back(mk(O_BNE,  0, 1, 1, 8));
    prog.push_back(mk(O_ADDI, 0, 0, 0, 7));
    prog.push_back(mk(O_SW,   0, 0, 0, 'h78));
    prog.push_back(mk(O_BEQ,  0, 1, 1, 8));
    prog.push_back(mk(O_ADDI, 8, 0, 0, 1));
    prog.push_back(mk(O_JAL,  7, 0, 0, 8));
    prog.push_back(mk(O_ADDI, 9, 0, 0, 1));
    prog.push_back(mk(O_SW,   0, 0, 7, 'h7C));
    for (int r = 1; r <= 10; r++) begin
      prog.push_back(mk(O_LUI,  r, 0, 0, int'($urandom_range(0, 'hFFFFF))));
      prog.push_back(mk(O_ADDI, r, r, 0, int'($urandom_range(0, 4095)) - 2048));
    end
    for (int n = 0; n < 40; n++) begin
      k = int'($urandom_range(0, 99));
      if (k < 15)
        prog.push_back(mk(O_SW, 0, 0, int'($urandom_range(0, 10)), 'h80 + 4 * int'($urandom_range(0, 31))));
      else if (k < 25)
        prog.push_back(mk(O_LW, int'($urandom_range(1, 10)), 0, 0, 4 * int'($urandom_range(0, 16))));
      else if (k < 40) begin
        int r1;
        r1 = int'($urandom_range(1, 10));
        prog.push_back(mk(($urandom_range(0, 1) == 0) ? O_BEQ : O_BNE, 0, r1,
                          ($urandom_range(0, 1) == 0) ? r1 : int'($urandom_range(1, 10)), 8));
        prog.push_back(rand_alu());
      end else
        prog.push_back(rand_alu());
    end
    for (int r = 1; r <= 10; r++) prog.push_back(mk(O_SW, 0, 0, r, 'h80 + 4 * r));
    prog.push_back(mk(O_ADDI, 1, 0, 0, 1));
    prog.push_back(mk(O_SLLI, 1, 1, 0, 4));
    prog.push_back(mk(O_SW,   0, 0, 1, 'hF0));
    prog.push_back(mk(O_ILL,  0, 0, 0, 0));
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem['h40 >> 2] = 32'h1234_5678;
    for (int i = 0; i < prog.size(); i++) mem[(RST_PC >> 2) + 32'(i)] = enc(prog[i]);
  endtask

  // Memory responder and monitor: random wait states, scoreboard pop on every completed transfer.
  initial begin : responder
    txn_t        e;
    bit          in_req = 1'b0, have_prev = 1'b0;
    int          wait_left = 0, waits = 0, cyc = 0, last_fetch = 0, prev_lat = 0;
    logic [31:0] h_adr, h_wd;
    logic        h_rd, h_wr;
    MemReady = 1'b0;
    ReadData = '0;
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        MemReady = 1'b0; in_req = 1'b0; have_prev = 1'b0; waits = 0;
      end else if (MemRead || MemWrite) begin
        if (MemRead && MemWrite) begin
          tests++; fails++;
          $display("FAIL rd_wr_overlap adr=%h", Adr);
        end
        if (!in_req) begin
          in_req = 1'b1; h_adr = Adr; h_wd = WriteData; h_rd = MemRead; h_wr = MemWrite;
          if (MemRead && Adr == 32'h40) wait_left = 3;
          else wait_left = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 2)) : 0;
        end else begin
          tests++;
          if (Adr !== h_adr || MemRead !== h_rd || MemWrite !== h_wr || (h_wr && WriteData !== h_wd)) begin
            fails++;
            $display("FAIL req_stable got adr=%h rd=%b wr=%b wd=%h required adr=%h rd=%b wr=%b wd=%h",
                     Adr, MemRead, MemWrite, WriteData, h_adr, h_rd, h_wr, h_wd);
          end
        end
        if (wait_left > 0) begin
          wait_left--; waits++; MemReady = 1'b0;
        end else begin
          MemReady = 1'b1; in_req = 1'b0;
          if (exp_q.size() == 0) begin
            tests++; fails++;
            $display("FAIL unexpected_req adr=%h rd=%b wr=%b required no request", Adr, MemRead, MemWrite);
          end else begin
            e = exp_q.pop_front();
            tests++;
            if (MemWrite !== (e.kind == 2) || Adr !== e.addr) begin
              fails++;
              $display("FAIL bus_txn got adr=%h wr=%b required adr=%h wr=%b", Adr, MemWrite, e.addr, e.kind == 2);
            end
            if (e.kind == 2) begin
              tests++;
              if (WriteData !== e.data) begin
                fails++;
                $display("FAIL store_data adr=%h got %h required %h", Adr, WriteData, e.data);
              end
            end
            if (e.kind == 0) begin
              if (have_prev) begin
                tests++;
                if (cyc - last_fetch != prev_lat + waits) begin
                  fails++;
                  $display("FAIL latency fetch=%h got %0d required %0d", Adr, cyc - last_fetch, prev_lat + waits);
                end
              end
              have_prev = 1'b1; last_fetch = cyc; prev_lat = e.lat; waits = 0;
            end
          end
          if (MemWrite) mem[Adr[11:2]] = WriteData;
          else ReadData = mem[Adr[11:2]];
        end
      end else begin
        MemReady = 1'b0;
      end
    end
  end

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s got %h required %h", name, got, want);
    end
  endtask

  initial begin : stimulus
    build_program();
    run_model();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("reset_adr", Adr, RST_PC);
    check("reset_memwrite", 32'(MemWrite), 32'd0);
    check("reset_halted", 32'(Halted), 32'd0);
    @(negedge clk);
    #1 reset = 1'b0;
    #1;
    check("first_fetch_adr", Adr, RST_PC);
    check("first_fetch_memread", 32'(MemRead), 32'd1);
    for (int i = 0; i < 20000 && !(Halted && exp_q.size() == 0); i++) @(negedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    check("halted", 32'(Halted), 32'd1);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      #1;
      check("halt_no_request", {30'd0, MemRead, MemWrite}, 32'd0);
    end
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    check("async_reset_halted", 32'(Halted), 32'd0);
    check("async_reset_adr", Adr, RST_PC);
    check("async_reset_memwrite", 32'(MemWrite), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
